// File: rtl/cv32e40s_pkg.sv
// Shared types and constants for the cv32e40s divider.
// Opcode and FSM encodings live here so decode and checking logic agree.
package cv32e40s_pkg;

    typedef enum logic [1:0] {
        DIV_DIV,
        DIV_DIVU,
        DIV_REM,
        DIV_REMU
    } div_opcode_e;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_DIVIDE,
        DIV_FINISH
    } div_state_e;

    localparam int unsigned DIV_ITERATIONS = 32;
    localparam int unsigned DIV_CNT_W      = $clog2(DIV_ITERATIONS);

    function automatic logic [31:0] div_abs(
        input logic [31:0] v,
        input logic        is_signed
    );
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/cv32e40s_div.sv
// Fixed-latency restoring divider for the RISC-V M extension.
// One quotient bit per cycle; sign fix-up applied on the way out.
module cv32e40s_div
    import cv32e40s_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  div_opcode_e operator_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        ready_i,
    output logic [31:0] result_o,
    output logic        valid_o,
    output logic        ready_o
);

    div_state_e             state_q;
    div_opcode_e            op_q;
    logic [DIV_CNT_W-1:0]   cnt_q;
    logic [32:0]            rem_q;
    logic [31:0]            quo_q;
    logic [31:0]            dvs_q;
    logic                   a_neg_q;
    logic                   b_neg_q;
    logic                   b_zero_q;

    logic                   in_signed;
    logic [33:0]            shifted;
    logic [33:0]            diff;
    logic                   borrow;
    logic [32:0]            rem_d;
    logic [31:0]            quo_d;

    logic                   is_rem;
    logic                   q_neg;
    logic [31:0]            quo_fix;
    logic [31:0]            rem_fix;
    logic [31:0]            res;

    always_comb begin
        in_signed = 1'b0;
        unique case (1'b1)
            (operator_i == DIV_DIV): in_signed = 1'b1;
            (operator_i == DIV_REM): in_signed = 1'b1;
            default:                 in_signed = 1'b0;
        endcase
    end

    // Restoring step: the dividend is shifted out of quo_q's MSB while
    // quotient bits fill in from the LSB.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        diff    = shifted - {2'b00, dvs_q};
        borrow  = diff[33];
        rem_d   = borrow ? shifted[32:0] : diff[32:0];
        quo_d   = {quo_q[30:0], ~borrow};
    end

    always_comb begin
        is_rem  = (op_q == DIV_REM) || (op_q == DIV_REMU);
        q_neg   = (a_neg_q ^ b_neg_q) & ~b_zero_q;
        quo_fix = q_neg   ? (~quo_q + 32'd1) : quo_q;
        rem_fix = a_neg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
        res     = is_rem ? rem_fix : quo_fix;
    end

    always_ff @(posedge clk) begin
        if (rst || !valid_i) begin
            state_q  <= DIV_IDLE;
            op_q     <= DIV_DIV;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    state_q  <= DIV_DIVIDE;
                    op_q     <= operator_i;
                    cnt_q    <= DIV_CNT_W'(DIV_ITERATIONS - 1);
                    rem_q    <= '0;
                    quo_q    <= div_abs(op_a_i, in_signed);
                    dvs_q    <= div_abs(op_b_i, in_signed);
                    a_neg_q  <= in_signed & op_a_i[31];
                    b_neg_q  <= in_signed & op_b_i[31];
                    b_zero_q <= (op_b_i == 32'd0);
                end
                DIV_DIVIDE: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0) begin
                        state_q <= DIV_FINISH;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DIV_FINISH: begin
                    if (ready_i) begin
                        state_q <= DIV_IDLE;
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        valid_o  = valid_i & ~rst & (state_q == DIV_FINISH);
        ready_o  = ~valid_i | (valid_o & ready_i);
        result_o = valid_o ? res : 32'd0;
    end

endmodule

// File: tb/tb_cv32e40s_div.sv
// Scoreboard bench for cv32e40s_div: directed corner cases plus random
// operations checked against a plain-arithmetic RISC-V reference.
module tb_cv32e40s_div;
    import cv32e40s_pkg::*;

    logic        clk;
    logic        rst;
    logic        valid_i;
    div_opcode_e operator_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        ready_i;
    logic [31:0] result_o;
    logic        valid_o;
    logic        ready_o;

    cv32e40s_div dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .operator_i (operator_i),
        .op_a_i     (op_a_i),
        .op_b_i     (op_b_i),
        .ready_i    (ready_i),
        .result_o   (result_o),
        .valid_o    (valid_o),
        .ready_o    (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    bit   first_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    function automatic logic [31:0] ref_model(input div_opcode_e op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (op)
            DIV_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            DIV_REMU: return (b == 0) ? a : a % b;
            DIV_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return 32'h8000_0000;
                return 32'(sa / sb);
            end
            default: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return 32'd0;
                return 32'(sa % sb);
            end
        endcase
    endfunction

    // Monitor: compares every presented result with the scoreboard head.
    always @(negedge clk) begin
        check("ready_o", {31'd0, ready_o},
              {31'd0, (~valid_i) | (valid_o & ready_i)});
        if (valid_o) begin
            if (sb_q.size() == 0) begin
                check("stale_valid", {31'd0, valid_o}, 32'd0);
            end else begin
                check("result", result_o, sb_q[0].res);
                if (!first_seen) begin
                    check("latency", 32'(cyc - sb_q[0].acc), 32'd33);
                    first_seen = 1'b1;
                end
                if (ready_i) begin
                    void'(sb_q.pop_front());
                    first_seen = 1'b0;
                end
            end
        end else begin
            check("result_idle", result_o, 32'd0);
        end
    end

    // Called #1 after an edge with the DUT idle.
    task automatic run_op(input div_opcode_e op, input logic [31:0] a,
                          input logic [31:0] b, input int hold,
                          input logic [31:0] exp);
        exp_t e;
        int   seen;
        bit   done;
        valid_i    = 1'b1;
        operator_i = op;
        op_a_i     = a;
        op_b_i     = b;
        ready_i    = (hold == 0);
        e.res      = exp;
        e.acc      = cyc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        operator_i = div_opcode_e'($urandom_range(0, 3));
        op_a_i     = $urandom;
        op_b_i     = $urandom;
        seen = 0;
        done = 1'b0;
        for (int k = 0; k < 120 && !done; k++) begin
            @(negedge clk);
            if (valid_o) begin
                if (ready_i) done = 1'b1;
                else seen++;
            end
            @(posedge clk);
            #1;
            if (seen >= hold) ready_i = 1'b1;
        end
        if (!done) begin
            n_total++;
            $display("FAIL timeout: op %0d a %h b %h no result in 120 cycles",
                     op, a, b);
            sb_q.delete();
            first_seen = 1'b0;
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'($urandom_range(1, 15));
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        div_opcode_e op;
        logic [31:0] a;
        logic [31:0] b;
        rst        = 1'b1;
        valid_i    = 1'b0;
        operator_i = DIV_DIVU;
        op_a_i     = '0;
        op_b_i     = '0;
        ready_i    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(DIV_DIVU, 32'd100, 32'd7, 0, 32'd14);
        run_op(DIV_REMU, 32'd100, 32'd7, 0, 32'd2);
        run_op(DIV_DIV, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD);
        run_op(DIV_REM, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF);
        run_op(DIV_DIV, 32'd7, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFD);
        run_op(DIV_REM, 32'd7, 32'hFFFF_FFFE, 0, 32'd1);
        run_op(DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
        run_op(DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0);
        run_op(DIV_DIVU, 32'd5, 32'd0, 0, 32'hFFFF_FFFF);
        run_op(DIV_REM, 32'hFFFF_FFFB, 32'd0, 0, 32'hFFFF_FFFB);
        run_op(DIV_DIVU, 32'd9, 32'd3, 5, 32'd3);

        // Kill in the middle of a divide, then a fresh operation.
        valid_i    = 1'b1;
        operator_i = DIV_DIVU;
        op_a_i     = 32'd1000;
        op_b_i     = 32'd3;
        ready_i    = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        run_op(DIV_DIVU, 32'd20, 32'd4, 0, 32'd5);

        // Reset in the middle of a divide.
        valid_i    = 1'b1;
        operator_i = DIV_DIV;
        op_a_i     = 32'd12345;
        op_b_i     = 32'd7;
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op(DIV_DIVU, 32'd1, 32'd1, 0, 32'd1);

        for (int i = 0; i < 40; i++) begin
            op = div_opcode_e'($urandom_range(0, 3));
            a  = rnd_operand();
            b  = rnd_operand();
            run_op(op, a, b, $urandom_range(0, 3), ref_model(op, a, b));
        end

        valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
